// File: rtl/seven_segment_mux_display.sv
// ---------------------------------------------------------------------------
// seven_segment_mux_display
//
// Time-multiplexed driver for a DIGITS-wide seven-segment bank. A packed
// multi-digit value, decimal points and blank / leading-zero-blank controls
// are taken through a valid/ready handshake into a shadow register. The
// shadow is copied into the display register only when the scan wraps back
// to digit 0, so a frame never mixes old and new digits. One digit is lit
// per REFRESH_DIV clock cycles.
//
// Build option:
//   SEVEN_SEG_HEX_DIGITS_EN  defined   -> nibbles 10..15 show A b C d E F
//                            undefined -> nibbles 10..15 are dark
//
// Parameters:
//   DIGITS          number of digits scanned (>= 1)
//   REFRESH_DIV     clock cycles each digit stays lit (>= 1)
//   SEG_ACTIVE_LOW  1 inverts io_segOut, io_dpOut and io_anode at the pins
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous reset, active low
//   io_valid   in   update request
//   io_ready   out  update accepted when io_valid && io_ready
//   io_value   in   4*DIGITS, nibble i = digit i (digit 0 rightmost)
//   io_dp      in   DIGITS, decimal point per digit
//   io_blank   in   1 = whole display dark
//   io_lzb     in   1 = leading-zero blanking
//   io_segOut  out  7, bit6 = a ... bit0 = g
//   io_dpOut   out  decimal point of the lit digit
//   io_anode   out  DIGITS, one-hot digit enable
//   io_frame   out  one-cycle pulse at the start of each frame
// ---------------------------------------------------------------------------
module seven_segment_mux_display #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_valid,
    output logic                  io_ready,
    input  logic [4*DIGITS-1:0]   io_value,
    input  logic [DIGITS-1:0]     io_dp,
    input  logic                  io_blank,
    input  logic                  io_lzb,
    output logic [6:0]            io_segOut,
    output logic                  io_dpOut,
    output logic [DIGITS-1:0]     io_anode,
    output logic                  io_frame
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam bit               INVERT   = (SEG_ACTIVE_LOW != 0);

    // Segment glyphs, a = bit6 ... g = bit0, active high.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h7E;
            4'd1:    seg = 7'h30;
            4'd2:    seg = 7'h6D;
            4'd3:    seg = 7'h79;
            4'd4:    seg = 7'h33;
            4'd5:    seg = 7'h5B;
            4'd6:    seg = 7'h5F;
            4'd7:    seg = 7'h70;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h7B;
`ifdef SEVEN_SEG_HEX_DIGITS_EN
            4'd10:   seg = 7'h77;
            4'd11:   seg = 7'h1F;
            4'd12:   seg = 7'h4E;
            4'd13:   seg = 7'h3D;
            4'd14:   seg = 7'h4F;
            4'd15:   seg = 7'h47;
`endif
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Scan control
    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic                pending;

    // Stage 0: shadow copy of the last accepted update
    logic [4*DIGITS-1:0] shadow_value_p0;
    logic [DIGITS-1:0]   shadow_dp_p0;
    logic                shadow_blank_p0;
    logic                shadow_lzb_p0;

    // Stage 1: data currently shown, swapped only at a frame wrap
    logic [4*DIGITS-1:0] disp_value_p1;
    logic [DIGITS-1:0]   disp_dp_p1;
    logic                disp_blank_p1;
    logic                disp_lzb_p1;

    logic tick;
    logic wrap;
    logic accept;

    assign tick   = (pre == PRE_LAST);
    assign wrap   = tick && (idx == IDX_LAST);
    assign accept = io_valid && io_ready;

    assign io_ready = !pending && reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pre             <= '0;
            idx             <= '0;
            pending         <= 1'b0;
            shadow_value_p0 <= '0;
            shadow_dp_p0    <= '0;
            shadow_blank_p0 <= 1'b1;
            shadow_lzb_p0   <= 1'b0;
            disp_value_p1   <= '0;
            disp_dp_p1      <= '0;
            disp_blank_p1   <= 1'b1;
            disp_lzb_p1     <= 1'b0;
        end else begin
            if (tick) begin
                pre <= '0;
                idx <= wrap ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end

            // Capture and commit are exclusive: capture needs pending=0,
            // commit needs pending=1.
            if (accept) begin
                shadow_value_p0 <= io_value;
                shadow_dp_p0    <= io_dp;
                shadow_blank_p0 <= io_blank;
                shadow_lzb_p0   <= io_lzb;
                pending         <= 1'b1;
            end else if (wrap && pending) begin
                disp_value_p1   <= shadow_value_p0;
                disp_dp_p1      <= shadow_dp_p0;
                disp_blank_p1   <= shadow_blank_p0;
                disp_lzb_p1     <= shadow_lzb_p0;
                pending         <= 1'b0;
            end
        end
    end

    // upper_zero[i] is set when nibbles DIGITS-1 down to i are all zero.
    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] upper_zero;

    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib[i]        = disp_value_p1[i*4 +: 4];
            all_zero      = all_zero && (nib[i] == 4'd0);
            upper_zero[i] = all_zero;
        end
    end

    logic [6:0]        seg_raw;
    logic              dp_raw;
    logic [DIGITS-1:0] anode_raw;

    always_comb begin
        seg_raw   = seg_decode(nib[idx]);
        dp_raw    = disp_dp_p1[idx];
        anode_raw = DIGITS'(1) << idx;
        // Leading-zero blanking darkens segments only; anode and dp stay.
        if (disp_lzb_p1 && upper_zero[idx] && (idx != '0)) begin
            seg_raw = '0;
        end
        if (disp_blank_p1) begin
            seg_raw   = '0;
            dp_raw    = 1'b0;
            anode_raw = '0;
        end
    end

    assign io_segOut = INVERT ? ~seg_raw   : seg_raw;
    assign io_dpOut  = INVERT ? ~dp_raw    : dp_raw;
    assign io_anode  = INVERT ? ~anode_raw : anode_raw;
    assign io_frame  = (idx == '0) && (pre == '0);

endmodule

// File: tb/tb_seven_segment_mux_display.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_mux_display
//
// Drives directed scenarios followed by random updates and resets into a
// DIGITS=4, REFRESH_DIV=4 instance, and compares every output each cycle
// against a cycle-count based reference model.
// ---------------------------------------------------------------------------
module tb_seven_segment_mux_display;

    localparam int D = 4;
    localparam int R = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io_valid = 1'b0;
    logic          io_ready;
    logic [4*D-1:0] io_value = '0;
    logic [D-1:0]  io_dp = '0;
    logic          io_blank = 1'b0;
    logic          io_lzb = 1'b0;
    logic [6:0]    io_segOut;
    logic          io_dpOut;
    logic [D-1:0]  io_anode;
    logic          io_frame;

    always #5 clock = ~clock;

    seven_segment_mux_display #(
        .DIGITS         (D),
        .REFRESH_DIV    (R),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_valid  (io_valid),
        .io_ready  (io_ready),
        .io_value  (io_value),
        .io_dp     (io_dp),
        .io_blank  (io_blank),
        .io_lzb    (io_lzb),
        .io_segOut (io_segOut),
        .io_dpOut  (io_dpOut),
        .io_anode  (io_anode),
        .io_frame  (io_frame)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time since reset release plus transaction-level state.
    int          k = 0;
    bit          m_pending = 1'b0;
    logic [15:0] sh_v = '0;
    logic [3:0]  sh_dp = '0;
    bit          sh_blank = 1'b1;
    bit          sh_lzb = 1'b0;
    logic [15:0] dv = '0;
    logic [3:0]  ddp = '0;
    bit          db = 1'b1;
    bit          dl = 1'b0;

    logic [6:0] dec_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    logic [6:0] hex_tbl [6]  = '{7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    function automatic logic [6:0] glyph(input int n);
        if (n < 10) return dec_tbl[n];
`ifdef SEVEN_SEG_HEX_DIGITS_EN
        return hex_tbl[n - 10];
`else
        return 7'h00;
`endif
    endfunction

    function automatic int cur_digit();
        return (k / R) % D;
    endfunction

    function automatic logic [6:0] exp_seg();
        int i;
        int upper;
        i = cur_digit();
        upper = int'(dv) >> (4 * i);
        if (db) return 7'h00;
        if (dl && i != 0 && upper == 0) return 7'h00;
        return glyph(upper % 16);
    endfunction

    task automatic step();
        bit acc;
        acc = reset && io_valid && !m_pending;
        @(posedge clock);
        if (!reset) begin
            k = 0; m_pending = 1'b0;
            sh_v = '0; sh_dp = '0; sh_blank = 1'b1; sh_lzb = 1'b0;
            dv = '0; ddp = '0; db = 1'b1; dl = 1'b0;
        end else begin
            k++;
            if (acc) begin
                sh_v = io_value; sh_dp = io_dp; sh_blank = io_blank; sh_lzb = io_lzb;
                m_pending = 1'b1;
            end else if (m_pending && (k % (R * D)) == 0) begin
                dv = sh_v; ddp = sh_dp; db = sh_blank; dl = sh_lzb;
                m_pending = 1'b0;
            end
        end
        #1;
        check("ready", 32'(io_ready), 32'(reset && !m_pending));
        check("frame", 32'(io_frame), 32'((k % (R * D)) == 0));
        check("anode", 32'(io_anode), db ? 32'd0 : (32'd1 << cur_digit()));
        check("seg",   32'(io_segOut), 32'(exp_seg()));
        check("dp",    32'(io_dpOut), db ? 32'd0 : 32'(ddp[cur_digit()]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset held three cycles.
        reset = 1'b0;
        run(3);

        // Release and request 0x1234 in the first cycle after reset.
        reset = 1'b1;
        io_valid = 1'b1; io_value = 16'h1234; io_dp = 4'b0100; io_blank = 1'b0; io_lzb = 1'b0;
        #1;
        check("t1_ready_release", 32'(io_ready), 32'd1);
        step();

        // Backpressure: 0x5678 offered while 0x1234 is pending.
        io_value = 16'h5678; io_dp = 4'b0000;
        run(15);
        check("t2_seg_first", 32'(io_segOut), 32'h33);
        check("t2_anode_first", 32'(io_anode), 32'h1);
        run(40);
        io_valid = 1'b0;
        run(20);

        // Leading-zero blanking.
        io_valid = 1'b1; io_value = 16'h0070; io_dp = 4'b0000; io_lzb = 1'b1;
        step();
        io_valid = 1'b0;
        run(40);

        // Hex nibbles.
        io_valid = 1'b1; io_value = 16'h00AF; io_lzb = 1'b0;
        step();
        io_valid = 1'b0;
        run(40);

        // Reset while an update is pending mid-frame.
        io_valid = 1'b1; io_value = 16'h9999; io_dp = 4'b1111;
        step();
        io_valid = 1'b0;
        run(8);
        reset = 1'b0;
        step();
        reset = 1'b1;
        run(40);

        // Random updates with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 149) != 0);
            io_valid = $urandom_range(0, 1);
            io_value = 16'($urandom);
            if ($urandom_range(0, 2) == 0) io_value[15:8] = 8'h00;
            io_dp    = 4'($urandom);
            io_blank = ($urandom_range(0, 5) == 0);
            io_lzb   = $urandom_range(0, 1);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
